// File: rtl/adc_ctrl_regfile.sv
// AXI4-Lite control/status register file for the ADC front-end, with gated
// reset outputs and an AXIS command FIFO fed by writes to the CMD register.
module adc_ctrl_regfile #(
  parameter int unsigned NUM_CFG    = 2,
  parameter int unsigned NUM_STATUS = 2,
  parameter int unsigned NUM_RST    = 3,
  parameter int unsigned AXIS_DEPTH = 8
) (
  input  logic                      aclk,
  input  logic                      aresetn,
  output logic [32*NUM_CFG-1:0]     cfg,
  input  logic [32*NUM_STATUS-1:0]  status,
  output logic [NUM_RST-1:0]        rst_n_out,
  output logic [31:0]               m_axis_tdata,
  output logic                      m_axis_tvalid,
  input  logic                      m_axis_tready,
  input  logic [31:0]               s_axi_lite_awaddr,
  input  logic [2:0]                s_axi_lite_awprot,
  input  logic                      s_axi_lite_awvalid,
  output logic                      s_axi_lite_awready,
  input  logic [31:0]               s_axi_lite_wdata,
  input  logic [3:0]                s_axi_lite_wstrb,
  input  logic                      s_axi_lite_wvalid,
  output logic                      s_axi_lite_wready,
  output logic [1:0]                s_axi_lite_bresp,
  output logic                      s_axi_lite_bvalid,
  input  logic                      s_axi_lite_bready,
  input  logic [31:0]               s_axi_lite_araddr,
  input  logic [2:0]                s_axi_lite_arprot,
  input  logic                      s_axi_lite_arvalid,
  output logic                      s_axi_lite_arready,
  output logic [31:0]               s_axi_lite_rdata,
  output logic [1:0]                s_axi_lite_rresp,
  output logic                      s_axi_lite_rvalid,
  input  logic                      s_axi_lite_rready
);

  localparam int unsigned PW = $clog2(AXIS_DEPTH);
  localparam int unsigned LW = PW + 1;
  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;
  localparam logic [5:0] IDX_CMD  = 6'h20;
  localparam logic [5:0] IDX_STAT = 6'h21;

  function automatic logic [31:0] merge(input logic [31:0] old_w, input logic [31:0] new_w,
                                        input logic [3:0] strb);
    logic [31:0] res;
    for (int b = 0; b < 4; b++) res[8*b +: 8] = strb[b] ? new_w[8*b +: 8] : old_w[8*b +: 8];
    return res;
  endfunction

  logic [31:0]   cfg_q [NUM_CFG];
  logic          aw_held, w_held;
  logic [5:0]    aw_idx;
  logic [31:0]   w_data;
  logic [3:0]    w_strb;
  logic [31:0]   mem [AXIS_DEPTH];
  logic [PW-1:0] wptr, rptr;
  logic [LW-1:0] level;
  logic          ovf;
  logic [31:0]   last_push;

  logic          aw_fire, w_fire, ar_fire, commit;
  logic [5:0]    wr_idx, rd_idx;
  logic [31:0]   wr_data, cmd_merged, fifo_stat, rd_data;
  logic [3:0]    wr_strb;
  logic          full, empty, pop, push, ovf_set, ovf_clr;
  logic [1:0]    wr_resp, rd_resp;
  logic          aw_held_next, w_held_next, bvalid_next, rvalid_next;
  logic          unused_ok;

  assign unused_ok = ^{s_axi_lite_awprot, s_axi_lite_arprot,
                       s_axi_lite_awaddr[31:8], s_axi_lite_awaddr[1:0],
                       s_axi_lite_araddr[31:8], s_axi_lite_araddr[1:0]};

  for (genvar g = 0; g < NUM_CFG; g++) begin : g_cfg
    assign cfg[32*g +: 32] = cfg_q[g];
  end

  assign rst_n_out     = cfg_q[0][NUM_RST-1:0] & {NUM_RST{aresetn}};
  assign m_axis_tdata  = mem[rptr];
  assign m_axis_tvalid = !empty;

  // Write path: a held channel payload takes precedence over the live bus.
  always_comb begin
    aw_fire      = s_axi_lite_awvalid & s_axi_lite_awready;
    w_fire       = s_axi_lite_wvalid & s_axi_lite_wready;
    wr_idx       = aw_held ? aw_idx : s_axi_lite_awaddr[7:2];
    wr_data      = w_held ? w_data : s_axi_lite_wdata;
    wr_strb      = w_held ? w_strb : s_axi_lite_wstrb;
    commit       = (aw_held | aw_fire) & (w_held | w_fire);
    aw_held_next = (aw_held | aw_fire) & !commit;
    w_held_next  = (w_held | w_fire) & !commit;
    bvalid_next  = commit | (s_axi_lite_bvalid & !s_axi_lite_bready);
    full         = (level == LW'(AXIS_DEPTH));
    empty        = (level == '0);
    pop          = !empty & m_axis_tready;
    cmd_merged   = merge(last_push, wr_data, wr_strb);
    push         = commit & (wr_idx == IDX_CMD) & (!full | pop);
    ovf_set      = commit & (wr_idx == IDX_CMD) & full & !pop;
    ovf_clr      = commit & (wr_idx == IDX_STAT) & wr_strb[3] & wr_data[31];
    fifo_stat    = {ovf, 13'd0, empty, full, 16'(level)};
    wr_resp      = RESP_SLVERR;
    for (int i = 0; i < NUM_CFG; i++) begin
      if (wr_idx == 6'(i)) wr_resp = RESP_OKAY;
    end
    if (wr_idx == IDX_CMD) wr_resp = ovf_set ? RESP_SLVERR : RESP_OKAY;
    if (wr_idx == IDX_STAT) wr_resp = RESP_OKAY;
  end

  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      aw_held            <= 1'b0;
      w_held             <= 1'b0;
      aw_idx             <= '0;
      w_data             <= '0;
      w_strb             <= '0;
      s_axi_lite_awready <= 1'b0;
      s_axi_lite_wready  <= 1'b0;
      s_axi_lite_bvalid  <= 1'b0;
      s_axi_lite_bresp   <= RESP_OKAY;
    end else begin
      aw_held            <= aw_held_next;
      w_held             <= w_held_next;
      if (aw_fire) aw_idx <= s_axi_lite_awaddr[7:2];
      if (w_fire) begin
        w_data <= s_axi_lite_wdata;
        w_strb <= s_axi_lite_wstrb;
      end
      s_axi_lite_awready <= !aw_held_next & !bvalid_next;
      s_axi_lite_wready  <= !w_held_next & !bvalid_next;
      s_axi_lite_bvalid  <= bvalid_next;
      if (commit) s_axi_lite_bresp <= wr_resp;
    end
  end

  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      for (int i = 0; i < NUM_CFG; i++) cfg_q[i] <= '0;
    end else begin
      for (int i = 0; i < NUM_CFG; i++) begin
        if (commit && wr_idx == 6'(i)) cfg_q[i] <= merge(cfg_q[i], wr_data, wr_strb);
      end
    end
  end

  // FIFO storage carries no reset; validity is tracked by level.
  always_ff @(posedge aclk) begin
    if (push) mem[wptr] <= cmd_merged;
  end

  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      wptr      <= '0;
      rptr      <= '0;
      level     <= '0;
      ovf       <= 1'b0;
      last_push <= '0;
    end else begin
      if (push) begin
        wptr      <= wptr + PW'(1);
        last_push <= cmd_merged;
      end
      if (pop) rptr <= rptr + PW'(1);
      if (push && !pop) level <= level + LW'(1);
      else if (pop && !push) level <= level - LW'(1);
      ovf <= ovf_set | (ovf & !ovf_clr);
    end
  end

  // Read path: decode is captured at the AR handshake.
  always_comb begin
    ar_fire     = s_axi_lite_arvalid & s_axi_lite_arready;
    rvalid_next = ar_fire | (s_axi_lite_rvalid & !s_axi_lite_rready);
    rd_idx      = s_axi_lite_araddr[7:2];
    rd_data     = '0;
    rd_resp     = RESP_SLVERR;
    for (int i = 0; i < NUM_CFG; i++) begin
      if (rd_idx == 6'(i)) begin
        rd_data = cfg_q[i];
        rd_resp = RESP_OKAY;
      end
    end
    for (int j = 0; j < NUM_STATUS; j++) begin
      if (rd_idx == 6'(16 + j)) begin
        rd_data = status[32*j +: 32];
        rd_resp = RESP_OKAY;
      end
    end
    if (rd_idx == IDX_CMD) begin
      rd_data = last_push;
      rd_resp = RESP_OKAY;
    end
    if (rd_idx == IDX_STAT) begin
      rd_data = fifo_stat;
      rd_resp = RESP_OKAY;
    end
  end

  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      s_axi_lite_arready <= 1'b0;
      s_axi_lite_rvalid  <= 1'b0;
      s_axi_lite_rdata   <= '0;
      s_axi_lite_rresp   <= RESP_OKAY;
    end else begin
      s_axi_lite_rvalid  <= rvalid_next;
      s_axi_lite_arready <= !rvalid_next;
      if (ar_fire) begin
        s_axi_lite_rdata <= rd_data;
        s_axi_lite_rresp <= rd_resp;
      end
    end
  end

endmodule
